// File: rtl/popcount_pipe.sv
// popcount_pipe: streaming population count, CHUNK-bit leaf counters feeding a registered adder tree.
// Optional POPCOUNT_ACCUM_EN: per-packet saturating totals (ACC_W bits), emitted on data_last_i beats.
module popcount_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4,
   parameter int unsigned ACC_W = 16,
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic             data_ready_o,
`ifdef POPCOUNT_ACCUM_EN
   input  logic             data_last_i,
   output logic [ACC_W-1:0] data_o,
`else
   output logic [CNT_W-1:0] data_o,
`endif
   output logic             data_val_o,
   input  logic             data_ready_i
);
   localparam int unsigned LEAVES = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int unsigned LEVELS = $clog2(LEAVES);
   localparam int unsigned PAD_W  = LEAVES * CHUNK;

   logic [PAD_W-1:0] padded;
   logic [CNT_W-1:0] nxt    [LEVELS+1][LEAVES];
   logic [CNT_W-1:0] node_q [LEVELS+1][LEAVES];
   logic [LEVELS:0]  val_q;
   logic [LEVELS:0]  val_in;
   logic [LEVELS:0]  load;
   logic             out_take;

   // Every level keeps LEAVES slots; slots past the live node count stay zero,
   // so an odd trailing node is simply added to zero.
   always_comb begin
      padded = PAD_W'(data_i);
      for (int unsigned i = 0; i < LEAVES; i++) begin
         nxt[0][i] = '0;
         for (int unsigned b = 0; b < CHUNK; b++)
            nxt[0][i] = nxt[0][i] + CNT_W'(padded[i*CHUNK + b]);
      end
      for (int unsigned k = 1; k <= LEVELS; k++) begin
         for (int unsigned i = 0; i < LEAVES; i++) begin
            nxt[k][i] = '0;
            if (2*i < LEAVES)
               nxt[k][i] = node_q[k-1][2*i];
            if (2*i + 1 < LEAVES)
               nxt[k][i] = nxt[k][i] + node_q[k-1][2*i + 1];
         end
      end
   end

   // Stage k loads unless it and every stage after it are full and the tail is not draining.
   always_comb begin
      val_in    = '0;
      val_in[0] = data_val_i;
      for (int unsigned k = 1; k <= LEVELS; k++)
         val_in[k] = val_q[k-1];
      for (int unsigned k = 0; k <= LEVELS; k++) begin
         load[k] = out_take;
         for (int unsigned j = k; j <= LEVELS; j++)
            if (!val_q[j])
               load[k] = 1'b1;
      end
   end

   assign data_ready_o = load[0];

`ifdef POPCOUNT_ACCUM_EN
   localparam int unsigned SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

   logic [LEVELS:0]  last_q;
   logic [LEVELS:0]  last_in;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] out_q;
   logic             out_val_q;
   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] sum_sat;

   always_comb begin
      last_in    = '0;
      last_in[0] = data_last_i;
      for (int unsigned k = 1; k <= LEVELS; k++)
         last_in[k] = last_q[k-1];
      sum      = SUM_W'(acc_q) + SUM_W'(node_q[LEVELS][0]);
      sum_sat  = (|sum[SUM_W-1:ACC_W]) ? '1 : sum[ACC_W-1:0];
      // Non-last beats always fold into the accumulator; only a last beat waits for the output slot.
      out_take = !last_q[LEVELS] || !out_val_q || data_ready_i;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         acc_q     <= '0;
         out_q     <= '0;
         out_val_q <= 1'b0;
      end else begin
         if (out_val_q && data_ready_i)
            out_val_q <= 1'b0;
         if (val_q[LEVELS] && out_take) begin
            if (last_q[LEVELS]) begin
               out_q     <= sum_sat;
               out_val_q <= 1'b1;
               acc_q     <= '0;
            end else begin
               acc_q <= sum_sat;
            end
         end
      end
   end

   assign data_o     = out_q;
   assign data_val_o = out_val_q;
`else
   assign out_take   = data_ready_i;
   assign data_o     = node_q[LEVELS][0];
   assign data_val_o = val_q[LEVELS];
`endif

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         val_q <= '0;
`ifdef POPCOUNT_ACCUM_EN
         last_q <= '0;
`endif
         for (int unsigned k = 0; k <= LEVELS; k++)
            for (int unsigned i = 0; i < LEAVES; i++)
               node_q[k][i] <= '0;
      end else begin
         for (int unsigned k = 0; k <= LEVELS; k++) begin
            if (load[k]) begin
               val_q[k] <= val_in[k];
               if (val_in[k]) begin
`ifdef POPCOUNT_ACCUM_EN
                  last_q[k] <= last_in[k];
`endif
                  for (int unsigned i = 0; i < LEAVES; i++)
                     node_q[k][i] <= nxt[k][i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_popcount_pipe.sv
// Self-checking bench for popcount_pipe: directed literal cases plus randomized backpressure
// against a queue-based reference model. Honours POPCOUNT_ACCUM_EN when defined.
module tb_popcount_pipe;
`ifdef POPCOUNT_ACCUM_EN
   localparam int unsigned OW   = 4;
   localparam int unsigned OW13 = 16;
   localparam int          ACC_MAX = 15;
`else
   localparam int unsigned OW   = 5;
   localparam int unsigned OW13 = 5;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          srst;
   logic [15:0]   din;
   logic          dval, dlast, drdy_o, drdy_i, dval_o;
   logic [OW-1:0] dout;
   logic [12:0]   din13;
   logic          dval13, dlast13, drdy13_o, drdy13_i, dval13_o;
   logic [OW13-1:0] dout13;

   popcount_pipe #(
      .WIDTH(16), .CHUNK(4)
`ifdef POPCOUNT_ACCUM_EN
      , .ACC_W(4)
`endif
   ) dut (
      .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .data_ready_o(drdy_o),
`ifdef POPCOUNT_ACCUM_EN
      .data_last_i(dlast),
`endif
      .data_o(dout), .data_val_o(dval_o), .data_ready_i(drdy_i)
   );

   popcount_pipe #(.WIDTH(13), .CHUNK(4)) dut13 (
      .clk_i(clk), .srst_i(srst), .data_i(din13), .data_val_i(dval13), .data_ready_o(drdy13_o),
`ifdef POPCOUNT_ACCUM_EN
      .data_last_i(dlast13),
`endif
      .data_o(dout13), .data_val_o(dval13_o), .data_ready_i(drdy13_i)
   );

   int checks = 0;
   int failures = 0;
   int exp_q[$];
   int acc = 0;
   logic          prev_stall = 1'b0;
   logic [OW-1:0] prev_dout = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model and compare process for the main DUT; transfers commit at the next posedge.
   always @(negedge clk) begin
      if (srst) begin
         exp_q.delete();
         acc = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", (dval_o && dout == prev_dout) ? 1 : 0, 1);
         if (dval_o && drdy_i) begin
            if (exp_q.size() == 0)
               chk("unexpected_out", int'(dout), -1);
            else
               chk("stream_out", int'(dout), exp_q.pop_front());
         end
         if (dval && drdy_o) begin
`ifdef POPCOUNT_ACCUM_EN
            acc = acc + $countones(din);
            if (acc > ACC_MAX) acc = ACC_MAX;
            if (dlast) begin
               exp_q.push_back(acc);
               acc = 0;
            end
`else
            exp_q.push_back($countones(din));
`endif
         end
         prev_stall = dval_o && !drdy_i;
         prev_dout  = dout;
      end
   end

   task automatic wait_main(input string name, input int exp);
      int n = 0;
      @(negedge clk);
      while (!dval_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_seen"}, int'(dval_o), 1);
      chk(name, int'(dout), exp);
   endtask

   task automatic drain();
      int n = 0;
      drdy_i = 1'b1;
      dval   = 1'b0;
      @(negedge clk);
      while ((exp_q.size() != 0 || dval_o) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      srst = 1'b1; din = 16'hFFFF; dval = 1'b1; dlast = 1'b1; drdy_i = 1'b1;
      din13 = '0; dval13 = 1'b0; dlast13 = 1'b1; drdy13_i = 1'b1;

      // Reset held with valid asserted.
      repeat (3) @(posedge clk);
      #1 srst = 1'b0; dval = 1'b0;
      @(negedge clk);
      chk("rst_val_o", int'(dval_o), 0);
      chk("rst_data_o", int'(dout), 0);
      chk("rst_ready_o", int'(drdy_o), 1);

`ifndef POPCOUNT_ACCUM_EN
      // Back-to-back literal words, exact latency.
      @(posedge clk); #1 dval = 1'b1; din = 16'h0000;
      @(posedge clk); #1 din = 16'hFFFF;
      @(posedge clk); #1 din = 16'hA5A5;
      @(negedge clk);
      chk("lat_not_early", int'(dval_o), 0);
      @(posedge clk); #1 din = 16'h0001;
      @(negedge clk);
      chk("seq0_val", int'(dval_o), 1);
      chk("seq0", int'(dout), 0);
      @(posedge clk); #1 dval = 1'b0;
      @(negedge clk); chk("seq1", dval_o ? int'(dout) : -1, 16);
      @(negedge clk); chk("seq2", dval_o ? int'(dout) : -1, 8);
      @(negedge clk); chk("seq3", dval_o ? int'(dout) : -1, 1);
      @(negedge clk); chk("seq_end_val", int'(dval_o), 0);

      // Fill with downstream stalled: three words buffered, then ready drops.
      drdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 dval = 1'b1; din = 16'($urandom);
         @(negedge clk);
         chk("fill_ready", int'(drdy_o), 1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("full_ready_low", int'(drdy_o), 0);
      @(posedge clk); #1 dval = 1'b0;
      @(negedge clk);
      chk("full_ready_still_low", int'(drdy_o), 0);
      drain();
`endif

      // Odd geometry: 13-bit word, padded last leaf.
      @(posedge clk); #1 dval13 = 1'b1; din13 = 13'h1FFF;
      @(posedge clk); #1 din13 = 13'h1000;
      @(posedge clk); #1 dval13 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!dval13_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("odd_seen", int'(dval13_o), 1);
      chk("odd_all_ones", int'(dout13), 13);
      @(negedge clk);
      chk("odd_pad_leaf", dval13_o ? int'(dout13) : -1, 1);

      // Randomized stream with 50% downstream backpressure.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         dval   = ($urandom_range(0, 9) < 7);
         din    = 16'($urandom);
         dlast  = ($urandom_range(0, 2) == 0);
         drdy_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      drain();

      // Reset with two words in flight: neither may ever appear.
      dlast = 1'b1; drdy_i = 1'b1;
      @(posedge clk); #1 dval = 1'b1; din = 16'($urandom);
      @(posedge clk); #1 din = 16'($urandom);
      @(posedge clk); #1 dval = 1'b0; srst = 1'b1;
      @(posedge clk); #1 srst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_no_out", int'(dval_o), 0);
      end

`ifdef POPCOUNT_ACCUM_EN
      // Packet totals, including saturation at 15.
      begin
         logic [15:0] w [4];
         logic        l [4];
         w = '{16'h00FF, 16'h000F, 16'hFFFF, 16'hFFFF};
         l = '{1'b0, 1'b1, 1'b0, 1'b1};
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 dval = 1'b1; din = w[i]; dlast = l[i];
         end
         @(posedge clk); #1 dval = 1'b0;
      end
      wait_main("acc_pkt1", 12);
      wait_main("acc_pkt2_sat", 15);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
